// File: rtl/trigger_stage_pkg.sv
// Shared definitions for one logic-analyzer trigger stage.
//   stage_state_t : FSM encoding (OFF, ARMED, MATCHED)
//   CFG_*         : bit positions of the fields inside the 32-bit config word
//   stage_cfg_t / decode_cfg : config word split into named fields
package trigger_stage_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ARMED   = 2'd1,
    MATCHED = 2'd2
  } stage_state_t;

  localparam int CFG_DELAY_LSB  = 0;
  localparam int CFG_DELAY_MSB  = 15;
  localparam int CFG_LEVEL_LSB  = 16;
  localparam int CFG_LEVEL_MSB  = 17;
  localparam int CFG_CHAN_LSB   = 20;
  localparam int CFG_CHAN_MSB   = 24;
  localparam int CFG_SERIAL_BIT = 26;
  localparam int CFG_START_BIT  = 27;

  typedef struct packed {
    logic [15:0] delay;
    logic [1:0]  level;
    logic [4:0]  channel;
    logic        serial;
    logic        start;
  } stage_cfg_t;

  function automatic stage_cfg_t decode_cfg(input logic [31:0] word);
    stage_cfg_t c;
    c.delay   = word[CFG_DELAY_MSB:CFG_DELAY_LSB];
    c.level   = word[CFG_LEVEL_MSB:CFG_LEVEL_LSB];
    c.channel = word[CFG_CHAN_MSB:CFG_CHAN_LSB];
    c.serial  = word[CFG_SERIAL_BIT];
    c.start   = word[CFG_START_BIT];
    return c;
  endfunction

endpackage

// File: rtl/trigger_stage_lut.sv
// 16x1 shift-loaded lookup table covering one data nibble.
//   clock, reset : clock and asynchronous active-low clear
//   shift        : shift din in at bit 0 this cycle
//   din          : next LUT bit
//   addr         : nibble value used as read address
//   hit          : LUT bit at addr (combinational)
// After 16 shifts the first bit written sits at address 15, so the parent
// loads addresses in descending order.
module trigger_lut16 (
  input  logic       clock,
  input  logic       reset,
  input  logic       shift,
  input  logic       din,
  input  logic [3:0] addr,
  output logic       hit
);

  logic [15:0] lut;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lut <= '0;
    end else if (shift) begin
      lut <= {lut[14:0], din};
    end
  end

  assign hit = lut[addr];

endmodule

// File: rtl/trigger_stage.sv
// One trigger stage: masked-value match against LUTs, programmable delay,
// then a one-cycle match pulse (and optional run pulse).
//   clock, reset : sample/config clock, asynchronous active-low reset
//   dataIn       : sampled channel data, qualified by validIn
//   validIn      : dataIn carries a sample this cycle
//   wrenb, din   : shift din[i] into the LUT for nibble i
//   wrConfig, config_data : load the config word
//   arm          : force the stage to ARMED
//   level        : current global trigger level
//   demux_mode   : serial mode takes two bits per sample
//   run, match   : registered one-cycle pulses
//   fsm_state    : current FSM state (debug view)
// Handshake: validIn is a plain qualifier with no backpressure; every cycle
// with validIn=1 consumes exactly one sample, cycles with validIn=0 are ignored
// by the matcher, the serial shifter and the delay counter.
module trigger_stage
  import trigger_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dataIn,
  input  logic        validIn,
  input  logic        wrenb,
  input  logic [7:0]  din,
  input  logic        wrConfig,
  input  logic [31:0] config_data,
  input  logic        arm,
  input  logic [1:0]  level,
  input  logic        demux_mode,
  output logic        run,
  output logic        match,
  output logic [1:0]  fsm_state
);

  logic [31:0]  config_q;
  stage_cfg_t   cfg;
  logic [31:0]  serial_sr;
  logic [31:0]  compare_src;
  logic [4:0]   chan_hi;
  logic [7:0]   hit_vec;
  logic         hit;
  logic         match_d;
  stage_state_t state, state_next;
  logic [15:0]  counter, counter_next;
  logic         run_next, match_next;

  // Reserved config bits have no function.
  logic unused_cfg;
  assign unused_cfg = ^{config_q[31:28], config_q[25], config_q[19:18]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      config_q <= '0;
    end else if (wrConfig) begin
      config_q <= config_data;
    end
  end

  assign cfg = decode_cfg(config_q);

  // Second serial channel is 16 above the primary one; 5-bit add wraps mod 32.
  assign chan_hi = cfg.channel + 5'd16;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      serial_sr <= '0;
    end else if (validIn) begin
      if (demux_mode) begin
        serial_sr <= {serial_sr[29:0], dataIn[cfg.channel], dataIn[chan_hi]};
      end else begin
        serial_sr <= {serial_sr[30:0], dataIn[cfg.channel]};
      end
    end
  end

  assign compare_src = cfg.serial ? serial_sr : dataIn;

  for (genvar g = 0; g < 8; g++) begin : g_lut
    trigger_lut16 u_lut (
      .clock (clock),
      .reset (reset),
      .shift (wrenb),
      .din   (din[g]),
      .addr  (compare_src[4*g +: 4]),
      .hit   (hit_vec[g])
    );
  end

  assign hit = &hit_vec;

  // match_d only moves on sample cycles, so it holds between samples.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      match_d <= 1'b0;
    end else if (validIn) begin
      match_d <= hit;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= OFF;
      counter <= '0;
      run     <= 1'b0;
      match   <= 1'b0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      run     <= run_next;
      match   <= match_next;
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    run_next     = 1'b0;
    match_next   = 1'b0;
    if (arm) begin
      state_next = ARMED;
    end else begin
      case (state)
        OFF: ;
        ARMED: begin
          if (match_d && (level >= cfg.level)) begin
            counter_next = cfg.delay;
            state_next   = MATCHED;
          end
        end
        MATCHED: begin
          if (validIn) begin
            if (counter == 16'd0) begin
              run_next   = cfg.start;
              match_next = 1'b1;
              state_next = OFF;
            end else begin
              counter_next = counter - 16'd1;
            end
          end
        end
        default: state_next = OFF;
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_trigger_stage.sv
// Self-checking bench for trigger_stage: per-cycle expected {run,match}
// values are queued as each sample is driven and compared after the edge.
module tb_trigger_stage;
  import trigger_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] dataIn = '0;
  logic        validIn = 1'b0;
  logic        wrenb = 1'b0;
  logic [7:0]  din = '0;
  logic        wrConfig = 1'b0;
  logic [31:0] config_data = '0;
  logic        arm = 1'b0;
  logic [1:0]  level = '0;
  logic        demux_mode = 1'b0;
  logic        run, match;
  logic [1:0]  fsm_state;

  logic [1:0]  exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  trigger_stage dut (
    .clock       (clock),
    .reset       (reset),
    .dataIn      (dataIn),
    .validIn     (validIn),
    .wrenb       (wrenb),
    .din         (din),
    .wrConfig    (wrConfig),
    .config_data (config_data),
    .arm         (arm),
    .level       (level),
    .demux_mode  (demux_mode),
    .run         (run),
    .match       (match),
    .fsm_state   (fsm_state)
  );

  // ---- clock / reset ----
  always #5 clock = ~clock;

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    validIn = 1'b0; wrenb = 1'b0; wrConfig = 1'b0; arm = 1'b0;
    level = '0; demux_mode = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // ---- checker ----
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---- drivers ----
  // LUT bit for address a: 1 when a equals value on every masked bit.
  task automatic load_lut(input logic [31:0] value, input logic [31:0] mask);
    for (int a = 15; a >= 0; a--) begin
      @(negedge clock);
      wrenb = 1'b1;
      validIn = 1'b0;
      for (int i = 0; i < 8; i++) begin
        logic [3:0] v_n, m_n, a_n;
        v_n = value[4*i +: 4];
        m_n = mask[4*i +: 4];
        a_n = 4'(a);
        din[i] = (((a_n ^ v_n) & m_n) == 4'd0);
      end
    end
    @(negedge clock);
    wrenb = 1'b0;
  endtask

  task automatic write_cfg(input logic [31:0] word);
    @(negedge clock);
    wrConfig = 1'b1;
    config_data = word;
    @(negedge clock);
    wrConfig = 1'b0;
  endtask

  task automatic do_arm();
    @(negedge clock);
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
  endtask

  // Drive one cycle, queue the expected {run,match} for the following edge.
  task automatic step(input string tag, input logic v, input logic [31:0] d, input logic [1:0] exp);
    logic [1:0] e;
    @(negedge clock);
    validIn = v;
    dataIn = d;
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check(tag, {30'd0, run, match}, {30'd0, e});
  endtask

  task automatic setup(input logic [31:0] value, input logic [31:0] mask, input logic [31:0] cfg_word);
    do_reset();
    load_lut(value, mask);
    write_cfg(cfg_word);
    do_arm();
  endtask

  // ---- stimulus ----
  initial begin
    logic [31:0] d;
    logic [1:0]  serial_bits[4];
    serial_bits[0] = 2'b01; serial_bits[1] = 2'b00;
    serial_bits[2] = 2'b01; serial_bits[3] = 2'b00;

    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_run", {31'd0, run}, 32'd0);
    check("reset_match", {31'd0, match}, 32'd0);
    check("reset_state", {30'd0, fsm_state}, {30'd0, OFF});
    reset = 1'b1;

    // Parallel exact match, delay 0, start=1.
    setup(32'h0000_00A5, 32'h0000_00FF, 32'h0800_0000);
    check("armed_state", {30'd0, fsm_state}, {30'd0, ARMED});
    step("par_s1", 1'b1, 32'h0000_00A5, 2'b00);
    step("par_s2", 1'b1, 32'h0000_00A5, 2'b00);
    step("par_fire", 1'b1, 32'h0000_00A5, 2'b11);
    step("par_after", 1'b1, 32'h0000_00A5, 2'b00);
    check("par_off", {30'd0, fsm_state}, {30'd0, OFF});

    // Near miss, then match with upper bits set (masked off).
    setup(32'h0000_00A5, 32'h0000_00FF, 32'h0800_0000);
    for (int k = 0; k < 4; k++) step("miss", 1'b1, 32'h0000_00A4, 2'b00);
    check("miss_armed", {30'd0, fsm_state}, {30'd0, ARMED});
    step("mask_s1", 1'b1, 32'hFFFF_FFA5, 2'b00);
    step("mask_s2", 1'b1, 32'hFFFF_FFA4, 2'b00);
    step("mask_fire", 1'b1, 32'hFFFF_FFA4, 2'b11);

    // Delay 3, start=0; gaps in validIn must stall the counter.
    setup(32'h0000_00A5, 32'h0000_00FF, 32'h0000_0003);
    step("dly_hit", 1'b1, 32'h0000_00A5, 2'b00);
    step("dly_enter", 1'b1, 32'h0000_00A5, 2'b00);
    check("dly_matched", {30'd0, fsm_state}, {30'd0, MATCHED});
    step("dly_c3", 1'b1, $urandom(), 2'b00);
    step("dly_gap1", 1'b0, $urandom(), 2'b00);
    step("dly_c2", 1'b1, $urandom(), 2'b00);
    step("dly_c1", 1'b1, $urandom(), 2'b00);
    for (int k = 0; k < $urandom_range(1, 4); k++) step("dly_gap2", 1'b0, $urandom(), 2'b00);
    step("dly_fire", 1'b1, $urandom(), 2'b01);
    step("dly_after", 1'b1, $urandom(), 2'b00);

    // Level gating: cfgLevel=2.
    setup(32'h0000_00A5, 32'h0000_00FF, 32'h0802_0000);
    level = 2'd1;
    step("lvl_hit", 1'b1, 32'h0000_00A5, 2'b00);
    for (int k = 0; k < 3; k++) step("lvl_low", 1'b1, 32'h0000_00A5, 2'b00);
    check("lvl_still_armed", {30'd0, fsm_state}, {30'd0, ARMED});
    level = 2'd2;
    step("lvl_enter", 1'b1, 32'h0000_00A5, 2'b00);
    step("lvl_fire", 1'b1, 32'h0000_00A5, 2'b11);

    // Serial, one bit per sample from channel 5: pattern 1,0,1,0.
    setup(32'h0000_000A, 32'h0000_000F, 32'h0C50_0000);
    for (int k = 0; k < 4; k++) begin
      d = $urandom();
      d[5] = serial_bits[k][0];
      step("ser_shift", 1'b1, d, 2'b00);
    end
    step("ser_hit", 1'b1, $urandom(), 2'b00);
    step("ser_enter", 1'b1, $urandom(), 2'b00);
    step("ser_fire", 1'b1, $urandom(), 2'b11);

    // Serial demux: two bits per sample (channel 5 then channel 21).
    setup(32'h0000_000A, 32'h0000_000F, 32'h0C50_0000);
    demux_mode = 1'b1;
    for (int k = 0; k < 2; k++) begin
      d = $urandom();
      d[5] = 1'b1;
      d[21] = 1'b0;
      step("dmx_shift", 1'b1, d, 2'b00);
    end
    step("dmx_hit", 1'b1, $urandom(), 2'b00);
    step("dmx_enter", 1'b1, $urandom(), 2'b00);
    step("dmx_fire", 1'b1, $urandom(), 2'b11);
    demux_mode = 1'b0;

    // Reset during the delay: no pulse, back to OFF.
    setup(32'h0000_00A5, 32'h0000_00FF, 32'h0800_0005);
    step("rst_hit", 1'b1, 32'h0000_00A5, 2'b00);
    step("rst_enter", 1'b1, 32'h0000_00A5, 2'b00);
    step("rst_count", 1'b1, 32'h0000_00A5, 2'b00);
    check("rst_pre_state", {30'd0, fsm_state}, {30'd0, MATCHED});
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_run", {31'd0, run}, 32'd0);
    check("rst_match", {31'd0, match}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, {30'd0, OFF});
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) step("rst_quiet", 1'b1, 32'h0000_00A5, 2'b00);
    check("rst_final_state", {30'd0, fsm_state}, {30'd0, OFF});

    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
